// File: rtl/keypad_pkg.sv
// keypad_pkg: debounce state type, special key codes and the 4x4 keypad layout
package keypad_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} deb_state_t;
    localparam logic [3:0] KEY_C     = 4'hC;
    localparam logic [3:0] KEY_STAR  = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;
    // nibble index = row*4 + col; rows: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    localparam logic [63:0] KEY_LAYOUT = 64'hDF0E_C987_B654_A321;
    function automatic logic [3:0] key_lookup(input logic [3:0] idx);
        return KEY_LAYOUT[{idx, 2'b00} +: 4];
    endfunction
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a key after DEBOUNCE identical frames and re-arms
// only after DEBOUNCE consecutive empty frames.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_stb,
    input  logic       i_key,
    input  logic [3:0] i_code,
    output logic       o_press
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    deb_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_code;
    logic [CW-1:0] w_cnt_inc;
    logic          w_same;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_same    = i_key && i_code == r_code;
    // the accepting frame is flagged combinationally so the caller registers all results together
    assign o_press   = i_en && i_stb && r_state == PRESS_WAIT && w_same && w_cnt_inc == CW'(DEBOUNCE);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_code  <= '0;
        end else if (!i_en) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (i_stb) begin
            case (r_state)
                IDLE: if (i_key) begin
                    r_state <= PRESS_WAIT;
                    r_cnt   <= CW'(1);
                    r_code  <= i_code;
                end
                PRESS_WAIT: if (!i_key) begin
                    r_state <= IDLE;
                end else if (!w_same) begin
                    r_cnt  <= CW'(1);
                    r_code <= i_code;
                end else begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc == CW'(DEBOUNCE)) r_state <= HELD;
                end
                HELD: if (!i_key) begin
                    r_state <= RELEASE_WAIT;
                    r_cnt   <= CW'(1);
                end
                RELEASE_WAIT: if (i_key) begin
                    r_state <= HELD;
                end else begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc == CW'(DEBOUNCE)) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/keypad_reader.sv
// keypad_reader: scans a 4x4 active-low keypad, decodes whole-frame key results
// and accumulates decimal digits into a binary value.
module keypad_reader
    import keypad_pkg::*;
#(
    parameter int SCAN_CNT   = 50000,
    parameter int DEBOUNCE   = 4,
    parameter int MAX_DIGITS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [23:0] value,
    output logic [2:0]  digit_cnt,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        done,
    output logic        overflow
);
    localparam int TW = SCAN_CNT > 1 ? $clog2(SCAN_CNT) : 1;
    logic [3:0]    r_col_s1, r_col_s2;
    logic [TW-1:0] r_tick_cnt;
    logic          r_active;
    logic [1:0]    r_row_idx;
    logic [1:0]    r_lows;
    logic [3:0]    r_key_idx;
    logic          r_entered;
    logic          w_tick, w_sample, w_frame_end, w_frame_key, w_press, w_digit;
    logic [2:0]    w_col_lows, w_lows_sum;
    logic [1:0]    w_lows_next, w_col_first;
    logic [3:0]    w_key_idx_next, w_code;
    assign w_tick      = enable && r_tick_cnt == TW'(SCAN_CNT - 1);
    assign w_sample    = w_tick && r_active;
    assign w_frame_end = w_sample && r_row_idx == 2'd3;
    assign row         = r_active ? ~(4'b0001 << r_row_idx) : 4'hF;
    // low-count saturates at 2: anything above one low in a frame means no key
    assign w_col_lows     = 3'($countones(~r_col_s2));
    assign w_col_first    = !r_col_s2[0] ? 2'd0 : !r_col_s2[1] ? 2'd1 : !r_col_s2[2] ? 2'd2 : 2'd3;
    assign w_lows_sum     = (r_row_idx == 2'd0 ? 3'd0 : {1'b0, r_lows}) + w_col_lows;
    assign w_lows_next    = w_lows_sum > 3'd1 ? 2'd2 : w_lows_sum[1:0];
    assign w_key_idx_next = w_col_lows != 3'd0 ? {r_row_idx, w_col_first} : r_key_idx;
    assign w_frame_key    = w_lows_next == 2'd1;
    assign w_code         = key_lookup(w_key_idx_next);
    assign w_digit        = w_code <= 4'd9;
    keypad_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .i_en   (enable),
        .i_stb  (w_frame_end),
        .i_key  (w_frame_key),
        .i_code (w_code),
        .o_press(w_press)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_s1   <= '0;
            r_col_s2   <= '0;
            r_tick_cnt <= '0;
            r_active   <= 1'b0;
            r_row_idx  <= '0;
            r_lows     <= '0;
            r_key_idx  <= '0;
        end else begin
            r_col_s1 <= col;
            r_col_s2 <= r_col_s1;
            if (!enable) begin
                r_tick_cnt <= '0;
                r_active   <= 1'b0;
                r_row_idx  <= '0;
                r_lows     <= '0;
            end else begin
                r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
                if (w_tick) begin
                    r_active  <= 1'b1;
                    r_row_idx <= r_active ? r_row_idx + 1'b1 : 2'd0;
                end
                if (w_sample) begin
                    r_lows    <= w_lows_next;
                    r_key_idx <= w_key_idx_next;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value     <= '0;
            digit_cnt <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            r_entered <= 1'b0;
        end else begin
            key_valid <= w_press;
            done      <= w_press && w_code == KEY_ENTER;
            if (w_press) begin
                key_code <= w_code;
                if (w_code == KEY_C) begin
                    value     <= '0;
                    digit_cnt <= '0;
                    overflow  <= 1'b0;
                    r_entered <= 1'b0;
                end else if (w_code == KEY_ENTER) begin
                    r_entered <= 1'b1;
                end else if (w_digit) begin
                    r_entered <= 1'b0;
                    // first digit after enter starts a fresh number
                    if (r_entered) begin
                        value     <= 24'(w_code);
                        digit_cnt <= 3'd1;
                        overflow  <= 1'b0;
                    end else if (digit_cnt < 3'(MAX_DIGITS)) begin
                        value     <= (value << 3) + (value << 1) + 24'(w_code);
                        digit_cnt <= digit_cnt + 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_reader.sv
// tb_keypad_reader: directed and random keypad sequences checked against a frame-level model
module tb_keypad_reader;
    localparam int DEB = 2;
    localparam logic [3:0] LAYOUT [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                           4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    typedef struct packed {
        logic [3:0]  code;
        logic [23:0] val;
        logic [2:0]  cnt;
        logic        done;
        logic        ovf;
    } ev_t;
    logic        clk = 1'b0, rst = 1'b0, enable = 1'b1;
    logic [3:0]  col, row, key_code;
    logic [23:0] value;
    logic [2:0]  digit_cnt;
    logic        key_valid, done, overflow;
    logic [15:0] keys = '0;
    ev_t         q_exp[$], q_act[$];
    int          n_tests = 0, n_fail = 0, n_stray = 0;
    int          m_run_code, m_run_len, m_cnt;
    bit          m_held, m_ovf, m_entered;
    logic [23:0] m_val;
    logic [3:0]  m_code;
    keypad_reader #(.SCAN_CNT(4), .DEBOUNCE(DEB), .MAX_DIGITS(7)) dut (
        .clk(clk), .rst(rst), .enable(enable), .col(col), .row(row), .value(value),
        .digit_cnt(digit_cnt), .key_valid(key_valid), .key_code(key_code), .done(done),
        .overflow(overflow)
    );
    always #5 clk = ~clk;
    always_comb begin
        col = 4'hF;
        for (int k = 0; k < 16; k++)
            if (keys[k] && !row[k / 4]) col[k % 4] = 1'b0;
    end
    always @(negedge clk) begin
        if (key_valid) q_act.push_back('{key_code, value, digit_cnt, done, overflow});
        if (done && !key_valid) n_stray++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic logic [15:0] mask_of(input logic [3:0] c);
        logic [15:0] m = '0;
        for (int k = 0; k < 16; k++) if (LAYOUT[k] == c) m[k] = 1'b1;
        return m;
    endfunction
    task automatic model_reset_scan();
        m_run_code = -1;
        m_run_len  = 0;
        m_held     = 1'b0;
    endtask
    task automatic model_reset_all();
        model_reset_scan();
        m_val = '0; m_cnt = 0; m_ovf = 1'b0; m_entered = 1'b0; m_code = '0;
    endtask
    task automatic model_key(input logic [3:0] c);
        ev_t e;
        m_code = c;
        e.done = 1'b0;
        if (c == 4'hC) begin
            m_val = '0; m_cnt = 0; m_ovf = 1'b0; m_entered = 1'b0;
        end else if (c == 4'hF) begin
            e.done = 1'b1; m_entered = 1'b1;
        end else if (c <= 4'd9) begin
            if (m_entered) begin m_val = '0; m_cnt = 0; m_ovf = 1'b0; m_entered = 1'b0; end
            if (m_cnt < 7) begin m_val = m_val * 10 + 24'(c); m_cnt++; end
            else m_ovf = 1'b1;
        end
        e.code = c; e.val = m_val; e.cnt = 3'(m_cnt); e.ovf = m_ovf;
        q_exp.push_back(e);
    endtask
    // debounce as run lengths of identical frame results (-1 = no key)
    task automatic model_frame(input logic [15:0] m);
        int r = -1;
        if ($countones(m) == 1)
            for (int k = 0; k < 16; k++) if (m[k]) r = int'(LAYOUT[k]);
        if (r == m_run_code) m_run_len++;
        else begin m_run_code = r; m_run_len = 1; end
        if (!m_held && r >= 0 && m_run_len == DEB) begin
            m_held = 1'b1;
            model_key(r[3:0]);
        end else if (m_held && r < 0 && m_run_len == DEB) begin
            m_held = 1'b0;
        end
    endtask
    task automatic sync_start();
        int g = 0;
        while (row == 4'b1110 && g < 100) begin @(negedge clk); g++; end
        while (row != 4'b1110 && g < 100) begin @(negedge clk); g++; end
        check("sync_wait", 32'(g < 100), 1);
    endtask
    task automatic frame(input logic [15:0] m);
        int g = 0;
        keys = m;
        while (row == 4'b1110 && g < 100) begin @(negedge clk); g++; end
        while (row != 4'b1110 && g < 100) begin @(negedge clk); g++; end
        check("frame_wait", 32'(g < 100), 1);
        model_frame(m);
    endtask
    task automatic tap(input logic [15:0] m, input int hold, input int rel);
        for (int i = 0; i < hold; i++) frame(m);
        for (int i = 0; i < rel; i++) frame('0);
    endtask
    task automatic checkpoint(input string tag);
        #1;
        check({tag, "_npulse"}, q_act.size(), q_exp.size());
        for (int i = 0; i < q_act.size() && i < q_exp.size(); i++) begin
            check({tag, "_code"}, 32'(q_act[i].code), 32'(q_exp[i].code));
            check({tag, "_val"}, 32'(q_act[i].val), 32'(q_exp[i].val));
            check({tag, "_cnt"}, 32'(q_act[i].cnt), 32'(q_exp[i].cnt));
            check({tag, "_done"}, 32'(q_act[i].done), 32'(q_exp[i].done));
            check({tag, "_ovf"}, 32'(q_act[i].ovf), 32'(q_exp[i].ovf));
        end
        check({tag, "_value"}, 32'(value), 32'(m_val));
        check({tag, "_digits"}, 32'(digit_cnt), 32'(m_cnt));
        check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, "_keycode"}, 32'(key_code), 32'(m_code));
        check({tag, "_stray_done"}, n_stray, 0);
        q_act.delete();
        q_exp.delete();
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_row"}, 32'(row), 32'hF);
        check({tag, "_value"}, 32'(value), 0);
        check({tag, "_digits"}, 32'(digit_cnt), 0);
        check({tag, "_key_valid"}, 32'(key_valid), 0);
        check({tag, "_key_code"}, 32'(key_code), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end
    initial begin
        logic [15:0] rm;
        model_reset_all();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        sync_start();
        tap(mask_of(4'h1), 3, 3);
        tap(mask_of(4'h2), 3, 3);
        tap(mask_of(4'h3), 3, 3);
        #1 check("seq123_pulses", q_act.size(), 3);
        checkpoint("seq123");
        check("seq123_const_value", 32'(value), 123);
        check("seq123_const_digits", 32'(digit_cnt), 3);
        tap(mask_of(4'h5), 1, 3);
        #1 check("bounce_pulses", q_act.size(), 0);
        checkpoint("bounce");
        check("bounce_const_value", 32'(value), 123);
        tap(mask_of(4'hC), 2, 2);
        for (int i = 0; i < 8; i++) tap(mask_of(4'h9), 2, 2);
        checkpoint("nines");
        check("nines_const_value", 32'(value), 9999999);
        check("nines_const_digits", 32'(digit_cnt), 7);
        check("nines_const_overflow", 32'(overflow), 1);
        tap(mask_of(4'hC), 2, 2);
        checkpoint("clear");
        check("clear_const_value", 32'(value), 0);
        check("clear_const_overflow", 32'(overflow), 0);
        tap(mask_of(4'h4), 2, 2);
        tap(mask_of(4'h2), 2, 2);
        tap(mask_of(4'hF), 2, 2);
        checkpoint("enter");
        check("enter_const_value", 32'(value), 42);
        tap(mask_of(4'h7), 2, 2);
        checkpoint("after_enter");
        check("after_enter_const_value", 32'(value), 7);
        check("after_enter_const_digits", 32'(digit_cnt), 1);
        tap(mask_of(4'h1) | mask_of(4'h6), 3, 0);
        tap(mask_of(4'h1), 3, 3);
        #1 check("multi_pulses", q_act.size(), 1);
        checkpoint("multi");
        check("multi_const_keycode", 32'(key_code), 1);
        frame(mask_of(4'h8));
        repeat (5) @(negedge clk);
        rst = 1'b0;
        keys = '0;
        #1 check_zero("midreset");
        q_act.delete();
        q_exp.delete();
        model_reset_all();
        @(negedge clk);
        rst = 1'b1;
        sync_start();
        tap(mask_of(4'h8), 1, 3);
        checkpoint("rst_bounce");
        tap(mask_of(4'h8), 2, 2);
        checkpoint("rst_fresh");
        for (int it = 0; it < 40; it++) begin
            rm = 16'(1) << $urandom_range(0, 15);
            if ($urandom_range(0, 9) == 0) rm = rm | (16'(1) << $urandom_range(0, 15));
            tap(rm, $urandom_range(1, 3), $urandom_range(0, 3));
            if (it % 8 == 7) checkpoint("rand");
        end
        tap('0, 0, 3);
        checkpoint("rand_end");
        enable = 1'b0;
        keys = mask_of(4'h5);
        repeat (3) @(negedge clk);
        check("dis_row", 32'(row), 32'hF);
        check("dis_value", 32'(value), 32'(m_val));
        repeat (60) @(negedge clk);
        check("dis_pulses", q_act.size(), 0);
        keys = '0;
        enable = 1'b1;
        model_reset_scan();
        sync_start();
        tap(mask_of(4'h5), 2, 2);
        checkpoint("reenable");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_reader.md
KEYPAD_READER -- requirements
Module: keypad_reader

Interface
REQ-001 SCAN_CNT, 50000, clk cycles per row dwell (scan tick period).
REQ-002 DEBOUNCE, 4, consecutive identical scan frames required to accept a press or a release.
REQ-003 MAX_DIGITS, 7, maximum decimal digits accumulated.
REQ-004 clk  input  1  single system clock; all logic on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  high = scan and accept keys; low = scanning halted.
REQ-007 col  input  4  keypad columns, active-low, externally pulled up, asynchronous.
REQ-008 row  output  4  keypad row drive, active-low one-hot.
REQ-009 value  output  24  binary value of digits entered.
REQ-010 digit_cnt  output  3  number of digits currently in value.
REQ-011 key_valid  output  1  one-cycle pulse per accepted key press.
REQ-012 key_code  output  4  code of last accepted key, held until next press.
REQ-013 done  output  1  one-cycle pulse on enter key.
REQ-014 overflow  output  1  sticky; digit rejected because digit_cnt == MAX_DIGITS.

Function
REQ-015 col SHALL pass through a 2-flop synchroniser before any use.
REQ-016 Tick counter SHALL count 0..SCAN_CNT-1 and emit a one-cycle tick at wrap; each tick advances the driven row 0->1->2->3->0.
REQ-017 col SHALL be sampled in the cycle of the tick ending a row's dwell; a frame is four consecutive row samples ending at row 3.
REQ-018 Frame result SHALL be "key r,c" only if exactly one col bit is low across the whole frame; zero lows = no key; more than one low = no key (multi-press ignored).
REQ-019 Layout (row r, col c): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D; codes: digits 0x0-0x9, A-D 0xA-0xD, * 0xE, # 0xF.
REQ-020 Debounce FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-021 IDLE -> PRESS_WAIT on a key frame; PRESS_WAIT counts frames with identical code; a differing code restarts the count with the new code; a no-key frame -> IDLE.
REQ-022 PRESS_WAIT -> HELD when count reaches DEBOUNCE; key_valid and key_code update in the cycle after that frame's final sample.
REQ-023 HELD -> RELEASE_WAIT on a no-key frame; RELEASE_WAIT -> IDLE after DEBOUNCE consecutive no-key frames; any key frame -> HELD with no new pulse.
REQ-024 Digit key: if digit_cnt < MAX_DIGITS, value <= value*10 + digit (computed as shift-add, 24-bit) and digit_cnt+1; else value unchanged and overflow <= 1.
REQ-025 C (0xC) SHALL clear value, digit_cnt and overflow.
REQ-026 # (0xF) SHALL pulse done with key_valid; value holds; the next digit key SHALL first clear value/digit_cnt/overflow, then append.
REQ-027 A, B, D, * SHALL pulse key_valid only; value unchanged.
REQ-028 value, digit_cnt, overflow, done SHALL be updated in the same cycle key_valid is high.
REQ-029 enable low SHALL force row = 4'hF, tick counter and FSM to reset state, suppress pulses; value, digit_cnt, overflow and key_code retained; rising enable restarts at row 0.
REQ-030 Maximum value 9,999,999 SHALL fit 24 bits without truncation.

Reset
REQ-031 rst low SHALL immediately set row = 4'hF, value = 0, digit_cnt = 0, key_valid = 0, key_code = 0, done = 0, overflow = 0, FSM = IDLE, all counters and synchroniser flops 0; first tick after release drives row 0.
REQ-032 Reset mid-debounce or mid-entry SHALL discard the pending press; no pulse after release until a fresh DEBOUNCE-frame press.

Structure
REQ-033 Package keypad_pkg SHALL hold the FSM state typedef, key code constants (KEY_C, KEY_STAR, KEY_ENTER) and the 4x4 layout table.
REQ-034 Sub-module keypad_debounce SHALL contain the REQ-020..023 FSM; keypad_reader holds scan, frame decode and accumulator.

Verification (bench SCAN_CNT = 4, DEBOUNCE = 2)
REQ-035 Press 1, 2, 3 each held 3 frames, released 3 frames -> three key_valid pulses, value = 123, digit_cnt = 3.
REQ-036 Key 5 held 1 frame only (bounce) -> no key_valid, value unchanged.
REQ-037 Enter 9 eight times -> value = 9,999,999, digit_cnt = 7, overflow = 1 after eighth; then C -> value 0, overflow 0.
REQ-038 Enter 4, 2, # -> done pulse with value = 42; then 7 -> value = 7, digit_cnt = 1.
REQ-039 Keys 1 and 6 held together -> no key_valid; release 6 keeping 1 -> one pulse, key_code = 0x1.
REQ-040 rst asserted during PRESS_WAIT of 8 -> outputs zero immediately; after release, 8 held 1 frame -> no pulse.
